// File: rtl/mcdf_pkg.sv
// Shared definitions for the MCDF arbiter: channel count, FSM state type
// and the packet-length code decoder.
package mcdf_pkg;

  localparam int NUM_CH = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  // Codes 0..4 select 1..16 words; every larger code saturates at a full FIFO (32).
  function automatic logic [5:0] len_decode(input logic [2:0] code);
    logic [5:0] words;
    case (code)
      3'd0:    words = 6'd1;
      3'd1:    words = 6'd2;
      3'd2:    words = 6'd4;
      3'd3:    words = 6'd8;
      3'd4:    words = 6'd16;
      default: words = 6'd32;
    endcase
    return words;
  endfunction

endpackage

// File: rtl/mcdf_prio_picker.sv
// Combinational winner selection: lowest priority value among eligible
// channels, ties broken round-robin from rr_start.
module mcdf_prio_picker
  import mcdf_pkg::*;
(
  input  logic [NUM_CH-1:0]      eligible,
  input  logic [NUM_CH-1:0][1:0] prio,
  input  logic [1:0]             rr_start,
  output logic [NUM_CH-1:0]      winner
);

  logic [1:0] best_prio;
  logic       found;
  logic       taken;
  logic [1:0] idx;

  // Find the best priority, then the first eligible channel holding it in rr order.
  always_comb begin
    best_prio = 2'd3;
    found     = 1'b0;
    taken     = 1'b0;
    idx       = 2'd0;
    winner    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (eligible[i] && (!found || prio[i] < best_prio)) begin
        best_prio = prio[i];
        found     = 1'b1;
      end
    end
    for (int k = 0; k < NUM_CH; k++) begin
      idx = 2'((int'(rr_start) + k) % NUM_CH);
      if (!taken && eligible[idx] && prio[idx] == best_prio) begin
        winner[idx] = 1'b1;
        taken       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mcdf_arbiter.sv
// MCDF arbiter: picks one of three channel FIFOs, requests the formatter,
// then streams the packet beats with start/end framing and FIFO pops.
module mcdf_arbiter
  import mcdf_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          slv0_en,
  input  logic          slv1_en,
  input  logic          slv2_en,
  input  logic [1:0]    slv0_prio,
  input  logic [1:0]    slv1_prio,
  input  logic [1:0]    slv2_prio,
  input  logic [2:0]    slv0_len,
  input  logic [2:0]    slv1_len,
  input  logic [2:0]    slv2_len,
  input  logic [5:0]    ch0_cnt,
  input  logic [5:0]    ch1_cnt,
  input  logic [5:0]    ch2_cnt,
  input  logic [DW-1:0] ch0_data,
  input  logic [DW-1:0] ch1_data,
  input  logic [DW-1:0] ch2_data,
  output logic [2:0]    ch_pop,
  output logic          fmt_req,
  input  logic          fmt_grant,
  output logic [1:0]    fmt_chid,
  output logic [5:0]    fmt_length,
  output logic          fmt_valid,
  output logic          fmt_start,
  output logic          fmt_end,
  output logic [DW-1:0] fmt_data,
  input  logic          fmt_ready
);

  logic [NUM_CH-1:0]         en_vec;
  logic [NUM_CH-1:0][1:0]    prio_vec;
  logic [NUM_CH-1:0][2:0]    len_vec;
  logic [NUM_CH-1:0][5:0]    cnt_vec;
  logic [NUM_CH-1:0][DW-1:0] data_vec;
  logic [NUM_CH-1:0]         eligible;
  logic [NUM_CH-1:0]         winner;
  logic [1:0]                win_idx;
  logic [5:0]                win_len;
  logic [1:0]                rr_start;
  logic [1:0]                last_winner;
  logic [5:0]                beat_cnt;
  logic                      beat_xfer;
  state_e                    state;

  assign en_vec   = {slv2_en, slv1_en, slv0_en};
  assign prio_vec = {slv2_prio, slv1_prio, slv0_prio};
  assign len_vec  = {slv2_len, slv1_len, slv0_len};
  assign cnt_vec  = {ch2_cnt, ch1_cnt, ch0_cnt};
  assign data_vec = {ch2_data, ch1_data, ch0_data};

  // A channel may compete only when its FIFO already holds a whole packet.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      eligible[i] = en_vec[i] && (cnt_vec[i] >= len_decode(len_vec[i]));
    end
  end

  // Search for a tie-break winner starts just after the previous packet's channel.
  assign rr_start = (last_winner == 2'd2) ? 2'd0 : last_winner + 2'd1;

  mcdf_prio_picker u_picker (
    .eligible (eligible),
    .prio     (prio_vec),
    .rr_start (rr_start),
    .winner   (winner)
  );

  // Convert the one-hot winner into a channel index.
  always_comb begin
    win_idx = 2'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (winner[i]) win_idx = 2'(i);
    end
  end

  assign win_len   = len_decode(len_vec[win_idx]);
  assign beat_xfer = (state == ST_SEND) && fmt_ready;

  // Packet FSM; channel and length are frozen on leaving IDLE so register
  // writes made mid-packet cannot disturb the packet in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      beat_cnt    <= 6'd0;
      last_winner <= 2'd2;
      fmt_chid    <= 2'd0;
      fmt_length  <= 6'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|eligible) begin
            state      <= ST_REQ;
            fmt_chid   <= win_idx;
            fmt_length <= win_len;
          end
        end
        ST_REQ: begin
          if (fmt_grant) begin
            state    <= ST_SEND;
            beat_cnt <= 6'd0;
          end
        end
        ST_SEND: begin
          if (beat_xfer) begin
            if (beat_cnt == fmt_length - 6'd1) begin
              state       <= ST_IDLE;
              last_winner <= fmt_chid;
            end else begin
              beat_cnt <= beat_cnt + 6'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign fmt_req   = (state == ST_REQ);
  assign fmt_valid = (state == ST_SEND);
  assign fmt_start = fmt_valid && (beat_cnt == 6'd0);
  assign fmt_end   = fmt_valid && (beat_cnt == fmt_length - 6'd1);
  assign fmt_data  = fmt_valid ? data_vec[fmt_chid] : '0;

  // Pop the owning FIFO exactly when a beat is accepted.
  always_comb begin
    ch_pop = '0;
    if (beat_xfer) ch_pop[fmt_chid] = 1'b1;
  end

endmodule
